// File: rtl/dm_sba_engine_pkg.sv
// dm_sba_engine_pkg: engine states and sberror codes for the system bus access engine.
package dm_sba_engine_pkg;
  typedef enum logic [2:0] {
    SbaIdle,
    SbaRead,
    SbaWrite,
    SbaWaitRead,
    SbaWaitWrite
  } sba_state_e;
  localparam logic [2:0] SbErrNone    = 3'd0;
  localparam logic [2:0] SbErrTimeout = 3'd1;
  localparam logic [2:0] SbErrBadAddr = 3'd2;
  localparam logic [2:0] SbErrAlign   = 3'd3;
  localparam logic [2:0] SbErrSize    = 3'd4;
  localparam logic [2:0] SbErrOther   = 3'd7;
endpackage

// File: rtl/dm_sba_lane_align.sv
// dm_sba_lane_align: byte-lane steering between 64-bit sbdata and a BusWidth-wide bus.
module dm_sba_lane_align #(
  parameter int BusWidth = 32
) (
  input  logic [$clog2(BusWidth/8)-1:0] lane_i,
  input  logic [2:0]                    size_i,
  input  logic [63:0]                   sbdata_i,
  input  logic [BusWidth-1:0]           rdata_i,
  output logic [BusWidth/8-1:0]         be_o,
  output logic [BusWidth-1:0]           wdata_o,
  output logic [63:0]                   rdata_o
);
  localparam int NB = BusWidth / 8;
  logic [7:0] size_be;
  logic [63:0] size_mask;
  logic [BusWidth-1:0] rdata_shift;
  logic [$clog2(NB)+2:0] bit_off;
  assign bit_off = {lane_i, 3'b000};
  assign size_be = size_i == 3'd0 ? 8'h01 : size_i == 3'd1 ? 8'h03 : size_i == 3'd2 ? 8'h0f : 8'hff;
  assign size_mask = size_i == 3'd0 ? 64'hff : size_i == 3'd1 ? 64'hffff :
                     size_i == 3'd2 ? 64'hffff_ffff : '1;
  assign be_o = NB'({8'd0, size_be} << lane_i);
  assign wdata_o = BusWidth'(sbdata_i << bit_off);
  assign rdata_shift = rdata_i >> bit_off;
  assign rdata_o = 64'(rdata_shift) & size_mask;
endmodule

// File: rtl/dm_sba_engine.sv
// dm_sba_engine: system bus access engine between the DMI sb* registers and a bus master port.
// Optional response timeout is built when DM_SBA_TIMEOUT_EN is defined.
module dm_sba_engine
  import dm_sba_engine_pkg::*;
#(
  parameter int BusWidth      = 32,
  parameter int AddrWidth     = 32,
  parameter int TimeoutCycles = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  dmactive_i,
  output logic                  master_req_o,
  output logic [AddrWidth-1:0]  master_add_o,
  output logic                  master_we_o,
  output logic [BusWidth-1:0]   master_wdata_o,
  output logic [BusWidth/8-1:0] master_be_o,
  input  logic                  master_gnt_i,
  input  logic                  master_r_valid_i,
  input  logic                  master_r_err_i,
  input  logic                  master_r_other_err_i,
  input  logic [BusWidth-1:0]   master_r_rdata_i,
  input  logic [AddrWidth-1:0]  sbaddress_i,
  input  logic                  sbaddress_write_valid_i,
  input  logic                  sbreadonaddr_i,
  input  logic                  sbautoincrement_i,
  input  logic [2:0]            sbaccess_i,
  input  logic                  sbreadondata_i,
  input  logic [63:0]           sbdata_i,
  input  logic                  sbdata_read_valid_i,
  input  logic                  sbdata_write_valid_i,
  output logic [AddrWidth-1:0]  sbaddress_o,
  output logic                  sbaddress_we_o,
  output logic [63:0]           sbdata_o,
  output logic                  sbdata_valid_o,
  output logic                  sbbusy_o,
  output logic                  sbbusyerror_o,
  output logic                  sberror_valid_o,
  output logic [2:0]            sberror_o
);
  localparam int NB = BusWidth / 8;
  localparam int LaneW = $clog2(NB);
  localparam logic [2:0] MaxAccess = 3'(LaneW);
  sba_state_e state_q, state_d;
  logic go_rd, go_wr, size_err, align_err, waiting, rsp, rsp_ok, timeout;
  logic err_v_d, data_v_d, addr_we_d, busyerr_d;
  logic [2:0] amask, err_d;
  logic [NB-1:0] be;
  logic [63:0] rdata_ext;
  // readonaddr outranks a data write, which outranks readondata
  assign go_rd = (sbaddress_write_valid_i && sbreadonaddr_i) ||
                 (!sbdata_write_valid_i && sbdata_read_valid_i && sbreadondata_i);
  assign go_wr = sbdata_write_valid_i && !(sbaddress_write_valid_i && sbreadonaddr_i);
  assign size_err = sbaccess_i > MaxAccess;
  assign amask = sbaccess_i == 3'd0 ? 3'd0 : sbaccess_i == 3'd1 ? 3'd1 : sbaccess_i == 3'd2 ? 3'd3 : 3'd7;
  assign align_err = |(sbaddress_i[2:0] & amask);
  assign waiting = state_q == SbaWaitRead || state_q == SbaWaitWrite;
  assign rsp = waiting && master_r_valid_i;
  assign rsp_ok = rsp && !master_r_err_i && !master_r_other_err_i;
  assign master_add_o = sbaddress_i;
  dm_sba_lane_align #(.BusWidth(BusWidth)) u_lane (
    .lane_i  (sbaddress_i[LaneW-1:0]),
    .size_i  (sbaccess_i),
    .sbdata_i(sbdata_i),
    .rdata_i (master_r_rdata_i),
    .be_o    (be),
    .wdata_o (master_wdata_o),
    .rdata_o (rdata_ext)
  );
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= SbaIdle;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      SbaIdle:  if ((go_rd || go_wr) && !size_err && !align_err) state_d = go_wr ? SbaWrite : SbaRead;
      SbaRead:  if (master_gnt_i) state_d = SbaWaitRead;
      SbaWrite: if (master_gnt_i) state_d = SbaWaitWrite;
      default:  if (rsp || timeout) state_d = SbaIdle;
    endcase
    if (!dmactive_i) state_d = SbaIdle;
  end
  always_comb begin
    master_req_o = dmactive_i && (state_q == SbaRead || state_q == SbaWrite);
    master_we_o = master_req_o && state_q == SbaWrite;
    master_be_o = master_req_o ? be : '0;
    sbbusy_o = state_q != SbaIdle;
    err_v_d = dmactive_i && ((state_q == SbaIdle && (go_rd || go_wr) && (size_err || align_err)) ||
                             (rsp && !rsp_ok) || timeout);
    err_d = state_q == SbaIdle ? (size_err ? SbErrSize : SbErrAlign) :
            !rsp ? SbErrTimeout : master_r_other_err_i ? SbErrOther : SbErrBadAddr;
    data_v_d = dmactive_i && rsp_ok && state_q == SbaWaitRead;
    addr_we_d = dmactive_i && rsp_ok && sbautoincrement_i;
    busyerr_d = dmactive_i && sbbusy_o &&
                (sbaddress_write_valid_i || sbdata_write_valid_i || sbdata_read_valid_i);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sbdata_o        <= '0;
      sbdata_valid_o  <= 1'b0;
      sbaddress_o     <= '0;
      sbaddress_we_o  <= 1'b0;
      sberror_valid_o <= 1'b0;
      sberror_o       <= SbErrNone;
      sbbusyerror_o   <= 1'b0;
    end else begin
      sbdata_o        <= data_v_d ? rdata_ext : sbdata_o;
      sbdata_valid_o  <= data_v_d;
      sbaddress_o     <= addr_we_d ? sbaddress_i + (AddrWidth'(1) << sbaccess_i) : sbaddress_o;
      sbaddress_we_o  <= addr_we_d;
      sberror_valid_o <= err_v_d;
      sberror_o       <= err_v_d ? err_d : SbErrNone;
      sbbusyerror_o   <= busyerr_d;
    end
  end
`ifdef DM_SBA_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] cnt_q;
  // counts only while staying in a wait state, so every wait starts from zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= (dmactive_i && waiting && state_d == state_q) ? cnt_q + CntW'(1) : '0;
  end
  assign timeout = waiting && !master_r_valid_i && cnt_q == CntW'(TimeoutCycles - 1);
`else
  logic unused_cfg;
  assign unused_cfg = ^TimeoutCycles;
  assign timeout = 1'b0;
`endif
endmodule

// File: doc/dm_sba_engine.md
Name: dm_sba_engine

Overview:
- Parametrised System Bus Access engine for the debug module; the next generation of the 32-bit-only SBA controller.
- Sits between the DMI register file (sbcs/sbaddress/sbdata) and the SoC bus master port.
- Adds:
  - configurable bus/address width, supporting 8/16/32/64-bit accesses;
  - registered read data and address-update outputs;
  - sbbusyerror detection;
  - an optional response timeout.

Parameters:
- BusWidth, 32, master data width in bits; legal values 32 or 64.
- AddrWidth, 32, system bus address width; 32..64.
- TimeoutCycles, 1024, cycles spent in a wait state before a timeout error (used only with the optional feature).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- dmactive_i  in  1  debug module active; low aborts the engine.
- master_req_o  out  1  bus request.
- master_add_o  out  AddrWidth  bus address; always equals sbaddress_i, not lane-aligned.
- master_we_o  out  1  write enable.
- master_wdata_o  out  BusWidth  write data, lane-shifted.
- master_be_o  out  BusWidth/8  byte enables.
- master_gnt_i  in  1  request granted.
- master_r_valid_i  in  1  response valid; marks both read and write completion.
- master_r_err_i  in  1  bus error response.
- master_r_other_err_i  in  1  other error response.
- master_r_rdata_i  in  BusWidth  read data.
- sbaddress_i  in  AddrWidth  current sbaddress.
- sbaddress_write_valid_i  in  1  debugger wrote sbaddress.
- sbreadonaddr_i  in  1  sbcs.sbreadonaddr.
- sbautoincrement_i  in  1  sbcs.sbautoincrement.
- sbaccess_i  in  3  sbcs.sbaccess; 0=8b, 1=16b, 2=32b, 3=64b.
- sbreadondata_i  in  1  sbcs.sbreadondata.
- sbdata_i  in  64  sbdata1:sbdata0.
- sbdata_read_valid_i  in  1  debugger read sbdata0.
- sbdata_write_valid_i  in  1  debugger wrote sbdata0.
- sbaddress_o  out  AddrWidth  incremented address; registered.
- sbaddress_we_o  out  1  one-cycle pulse: load sbaddress_o.
- sbdata_o  out  64  read result, zero-extended; registered.
- sbdata_valid_o  out  1  one-cycle pulse: load sbdata_o.
- sbbusy_o  out  1  engine not Idle.
- sbbusyerror_o  out  1  one-cycle pulse: access attempted while busy.
- sberror_valid_o  out  1  one-cycle pulse.
- sberror_o  out  3  error code, valid with sberror_valid_o.

Behaviour:
- Reset values:
  - state Idle;
  - all pulses 0;
  - sbdata_o 0 and sbaddress_o 0;
  - master_req_o 0 and master_we_o 0;
  - master_be_o 0;
  - timeout counter 0.
- sbbusy_o = (state != Idle), combinational from state.
- States are Idle, Read, Write, WaitRead, WaitWrite.
- Idle transitions, in priority order:
  1. sbaddress_write_valid_i && sbreadonaddr_i -> Read.
  2. sbdata_write_valid_i -> Write.
  3. sbdata_read_valid_i && sbreadondata_i -> Read.
- Size/alignment check on entry to Read or Write, before any request:
  - MaxAccess = log2(BusWidth/8).
  - sbaccess_i > MaxAccess -> sberror 4 pulse, return to Idle, master_req_o stays 0.
  - Otherwise, sbaddress_i not aligned to 2^sbaccess_i -> sberror 3 pulse, return to Idle.
  - If both faults are present, code 4 wins.
- Read/Write states:
  - Drive master_req_o=1 and master_be_o, plus master_we_o=1 in Write.
  - Hold all master outputs stable until master_gnt_i.
  - On master_gnt_i -> WaitRead/WaitWrite; master_req_o=0 in the next cycle.
- Lane alignment:
  - lane = sbaddress_i[log2(BusWidth/8)-1:0].
  - master_be_o = ((1<<(1<<sbaccess)) - 1) << lane.
  - master_wdata_o = sbdata_i[BusWidth-1:0] << (8*lane).
- WaitRead/WaitWrite, on master_r_valid_i:
  - Go to Idle.
  - master_r_other_err_i -> sberror 7.
  - Else master_r_err_i -> sberror 2.
  - If neither error is set:
    - in WaitRead, sbdata_o <= (rdata >> 8*lane) masked to 8*2^sbaccess bits, and sbdata_valid_o pulses the next cycle (latency 1 from r_valid);
    - if sbautoincrement_i, sbaddress_o <= sbaddress_i + (1<<sbaccess_i) with AddrWidth wrap-around, and sbaddress_we_o pulses.
  - On error: no data update and no address increment.
- sbbusyerror_o pulses when sbaddress_write_valid_i, sbdata_write_valid_i or sbdata_read_valid_i is seen while state != Idle. The access is dropped and the state is unchanged.
- dmactive_i low:
  - synchronous return to Idle from any state;
  - master_req_o=0, pulses suppressed, timeout counter cleared;
  - a master_r_valid_i arriving later in Idle is ignored.
- A simultaneous grant and r_valid in Read/Write is illegal on this bus; the engine ignores the r_valid.

Optional Feature:
- Macro: DM_SBA_TIMEOUT_EN.
- Defined:
  - a counter of width $clog2(TimeoutCycles+1) increments each cycle in WaitRead/WaitWrite;
  - it clears on entry to a wait state;
  - on reaching TimeoutCycles without r_valid: sberror 1, state Idle, no data or address update.
  - An r_valid in the expiry cycle wins over the timeout.
- Undefined: no counter exists; wait states last indefinitely; code 1 is never produced.

Decomposition:
- dm package gains:
  - sba_state_e (5 states);
  - sberror localparams: SbErrNone=0, SbErrTimeout=1, SbErrBadAddr=2, SbErrAlign=3, SbErrSize=4, SbErrOther=7.
- One sub-module, dm_sba_lane_align (parameter BusWidth), purely combinational. It produces the byte-enable mask, the write-data shift and the read-data extract/zero-extend.

Test Plan:
- BusWidth=64; 32-bit read at 0x1004, readonaddr=1; rdata=0xAABBCCDD_11223344 -> be=0xF0, one req until gnt; sbdata_o=0xAABBCCDD and sbdata_valid_o pulse 1 cycle after r_valid.
- Write of sbdata=0x5A, sbaccess=0, addr 0x2003, autoincrement=1 -> be=0x08, wdata=0x5A<<24, we=1; sbaddress_o=0x2004 with sbaddress_we_o pulse.
- BusWidth=32: sbaccess=3 -> sberror 4, no req. sbaccess=2 at addr 0x2 -> sberror 3, no req.
- r_err and r_other_err both set on a read -> sberror 7, sbdata_valid_o=0, address unchanged.
- sbdata_write_valid_i while in WaitWrite -> sbbusyerror_o pulse, no second write issued. dmactive_i low in WaitRead -> Idle next cycle; a later r_valid yields no pulse.
- With DM_SBA_TIMEOUT_EN and TimeoutCycles=8, r_valid never arrives -> sberror 1 exactly 8 cycles after entering WaitRead, then sbbusy_o=0.
